// File: rtl/mos_pkg.sv
// Shared strength type, net-state enum and wired-net resolve function for the
// MOS pass-gate and net-resolution stages.
package mos_pkg;

  typedef enum logic [1:0] {
    ST0 = 2'd0,
    ST1 = 2'd1,
    STZ = 2'd2,
    STX = 2'd3
  } t_strength;

  typedef enum logic [1:0] {
    FLOAT,
    DRIVEN,
    HOLD,
    CONTEND
  } t_net_state;

  // Wired resolution of two drivers: Z yields to anything, X dominates, 0 vs 1 is X.
  function automatic t_strength mos_resolve(input t_strength a, input t_strength b);
    t_strength r;
    if (a == STX || b == STX) r = STX;
    else if (a == STZ)        r = b;
    else if (b == STZ)        r = a;
    else if (a == b)          r = a;
    else                      r = STX;
    return r;
  endfunction

  function automatic logic is_drive(input t_strength s);
    return (s == ST0) || (s == ST1);
  endfunction

endpackage

// File: rtl/mos_glitch_filter.sv
// Run-length glitch filter: strobes acc_stb on the edge where the resolved value
// has been seen FILTER_DEPTH consecutive times.
module mos_glitch_filter
  import mos_pkg::*;
#(
  parameter int unsigned FILTER_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  t_strength r,
  output t_strength acc_val,
  output logic      acc_stb
);

  if (FILTER_DEPTH < 1 || FILTER_DEPTH > 15) begin : g_bad_depth
    $error("mos_glitch_filter: FILTER_DEPTH must be 1..15");
  end

  localparam logic [3:0] DEPTH_M1 = 4'(FILTER_DEPTH - 1);

  t_strength  sample_q, sample_d;
  logic [3:0] stab_cnt_q, stab_cnt_d;

  // stab_cnt saturates so a long steady run can never re-trigger acceptance.
  always_comb begin
    sample_d   = r;
    stab_cnt_d = '0;
    if (r == sample_q) begin
      stab_cnt_d = (stab_cnt_q == 4'hF) ? stab_cnt_q : stab_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q   <= STZ;
      stab_cnt_q <= '0;
    end else begin
      sample_q   <= sample_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign acc_val = r;
  assign acc_stb = (stab_cnt_d == DEPTH_M1);

endmodule

// File: rtl/mos_net_resolver.sv
// Net resolver: resolve, glitch-filter, net FSM with optional bus keeper and a
// saturating contention counter. Keeper built only when MOS_NET_KEEPER_EN is defined.
module mos_net_resolver
  import mos_pkg::*;
#(
  parameter int unsigned FILTER_DEPTH = 2,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  t_strength  drv_n,
  input  t_strength  drv_p,
  input  logic       cnt_clr,
  output t_strength  net,
  output logic       contention,
  output logic       decay,
  output logic [7:0] contention_cnt
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("mos_net_resolver: HOLD_CYCLES must be 1..255");
  end

  t_strength  r, acc_val;
  logic       acc_stb;
  t_net_state state_q, state_d;
  t_strength  net_q, net_d;
  logic       contention_q, contention_d;
  logic       decay_q, decay_d;
  logic [7:0] cnt_q, cnt_d;
`ifdef MOS_NET_KEEPER_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  assign r = mos_resolve(drv_n, drv_p);

  mos_glitch_filter #(
    .FILTER_DEPTH(FILTER_DEPTH)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .r      (r),
    .acc_val(acc_val),
    .acc_stb(acc_stb)
  );

  // An accepted drive or X always wins, including over keeper expiry on the same edge.
  always_comb begin
    state_d = state_q;
    net_d   = net_q;
    decay_d = 1'b0;
`ifdef MOS_NET_KEEPER_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (acc_stb && is_drive(acc_val)) begin
      state_d = DRIVEN;
      net_d   = acc_val;
    end else if (acc_stb && acc_val == STX) begin
      state_d = CONTEND;
      net_d   = STX;
    end else begin
      case (state_q)
        DRIVEN: begin
          if (acc_stb) begin
`ifdef MOS_NET_KEEPER_EN
            state_d    = HOLD;
            hold_cnt_d = HOLD_INIT;
`else
            state_d = FLOAT;
            net_d   = STZ;
`endif
          end
        end
        CONTEND: begin
          if (acc_stb) begin
            state_d = FLOAT;
            net_d   = STZ;
          end
        end
        HOLD: begin
`ifdef MOS_NET_KEEPER_EN
          if (hold_cnt_q <= 8'd1) begin
            state_d    = FLOAT;
            net_d      = STZ;
            decay_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end
`else
          state_d = FLOAT;
          net_d   = STZ;
`endif
        end
        default: ;
      endcase
    end

    contention_d = (state_d == CONTEND) && (state_q != CONTEND);

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (contention_d && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FLOAT;
      net_q        <= STZ;
      contention_q <= 1'b0;
      decay_q      <= 1'b0;
      cnt_q        <= '0;
`ifdef MOS_NET_KEEPER_EN
      hold_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      net_q        <= net_d;
      contention_q <= contention_d;
      decay_q      <= decay_d;
      cnt_q        <= cnt_d;
`ifdef MOS_NET_KEEPER_EN
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign net            = net_q;
  assign contention     = contention_q;
  assign decay          = decay_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mos_net_resolver.sv
// Directed bench for mos_net_resolver: per-cycle comparison against a run-length
// behavioural model plus literal expectations for each scenario.
module tb_mos_net_resolver;
  import mos_pkg::*;

  localparam int DEPTH = 2;
  localparam int HOLDC = 8;
`ifdef MOS_NET_KEEPER_EN
  localparam int KEEP = 1;
`else
  localparam int KEEP = 0;
`endif

  localparam int M_FLT = 0;
  localparam int M_DRV = 1;
  localparam int M_HLD = 2;
  localparam int M_CON = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_clr = 1'b0;
  t_strength  drv_n = STZ;
  t_strength  drv_p = STZ;
  t_strength  net;
  logic       contention;
  logic       decay;
  logic [7:0] contention_cnt;

  always #5 clk = ~clk;

  mos_net_resolver #(
    .FILTER_DEPTH(DEPTH),
    .HOLD_CYCLES (HOLDC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drv_n         (drv_n),
    .drv_p         (drv_p),
    .cnt_clr       (cnt_clr),
    .net           (net),
    .contention    (contention),
    .decay         (decay),
    .contention_cnt(contention_cnt)
  );

  int checks = 0;
  int errors = 0;
  int m_prev, m_run, m_mode, m_left, m_net, m_cnt, m_cont, m_decay;
  int cont_seen = 0;
  int decay_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strength codes: 0=ST0 1=ST1 2=Z 3=X
  function automatic int model_resolve(input int a, input int b);
    if (a == b) return a;
    if (a == 2) return b;
    if (b == 2) return a;
    return 3;
  endfunction

  task automatic model_edge();
    int rv;
    m_cont  = 0;
    m_decay = 0;
    if (!rst_n) begin
      m_prev = 2; m_run = 1; m_mode = M_FLT; m_left = 0; m_net = 2; m_cnt = 0;
      return;
    end
    rv = model_resolve(int'(drv_n), int'(drv_p));
    if (rv == m_prev) m_run++;
    else m_run = 1;
    m_prev = rv;
    if (m_run == DEPTH && (rv == 0 || rv == 1)) begin
      m_mode = M_DRV; m_net = rv;
    end else if (m_run == DEPTH && rv == 3) begin
      if (m_mode != M_CON) begin
        m_cont = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_mode = M_CON; m_net = 3;
    end else if (m_run == DEPTH && m_mode == M_DRV) begin
      if (KEEP == 1) begin
        m_mode = M_HLD; m_left = HOLDC;
      end else begin
        m_mode = M_FLT; m_net = 2;
      end
    end else if (m_run == DEPTH && m_mode == M_CON) begin
      m_mode = M_FLT; m_net = 2;
    end else if (m_mode == M_HLD) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = M_FLT; m_net = 2; m_decay = 1;
      end
    end
    if (cnt_clr) m_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("net", int'(net), m_net);
    check("contention", int'(contention), m_cont);
    check("decay", int'(decay), m_decay);
    check("contention_cnt", int'(contention_cnt), m_cnt);
    cont_seen  += int'(contention);
    decay_seen += int'(decay);
  endtask

  task automatic cyc(input t_strength n, input t_strength p, input int k);
    drv_n = n;
    drv_p = p;
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    int n;
    int bad;

    rst_n = 1'b0;
    cyc(STZ, STZ, 2);
    check("reset_net", int'(net), int'(STZ));
    check("reset_cnt", int'(contention_cnt), 0);
    check("reset_pulses", int'(contention) + int'(decay), 0);
    $display("reset: net=%0d cnt=%0d", net, contention_cnt);

    rst_n = 1'b1;
    drv_n = ST0;
    drv_p = STZ;
    step();
    check("clean_edge1", int'(net), int'(STZ));
    step();
    check("clean_edge2", int'(net), int'(ST0));
    check("clean_no_contention", cont_seen, 0);
    $display("clean drive: net=%0d", net);

    cyc(ST0, STZ, 2);
    bad = 0;
    drv_n = ST1;
    step();
    if (net != ST0) bad++;
    drv_n = ST0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (net != ST0) bad++;
    end
    check("glitch_reject", bad, 0);
    $display("glitch: cycles off ST0=%0d", bad);

    cyc(ST1, STZ, 3);
    check("keeper_driven", int'(net), int'(ST1));
    decay_seen = 0;
    drv_n = STZ;
    drv_p = STZ;
    n = 0;
    while (net != STZ && n < 50) begin
      step();
      n++;
    end
    check("release_latency", n, (KEEP == 1) ? DEPTH + HOLDC : DEPTH);
    cyc(STZ, STZ, 3);
    check("decay_pulses", decay_seen, KEEP);
    $display("release: cycles to Z=%0d decay pulses=%0d", n, decay_seen);

    cyc(ST0, STZ, 3);
    cont_seen = 0;
    cyc(ST0, ST1, 3);
    check("contend_net", int'(net), int'(STX));
    check("contend_pulses", cont_seen, 1);
    check("contend_cnt1", int'(contention_cnt), 1);
    $display("contention: net=%0d cnt=%0d", net, contention_cnt);

    for (int i = 0; i < 300; i++) begin
      cyc(ST0, STZ, 2);
      cyc(ST0, ST1, 2);
    end
    check("contend_saturate", int'(contention_cnt), 255);
    $display("saturation: cnt=%0d", contention_cnt);

    cyc(ST0, STZ, 3);
    drv_n = ST0;
    drv_p = ST1;
    step();
    cnt_clr = 1'b1;
    cont_seen = 0;
    step();
    cnt_clr = 1'b0;
    check("clear_wins_cnt", int'(contention_cnt), 0);
    check("clear_wins_pulse", cont_seen, 1);
    cyc(ST0, STZ, 2);
    cyc(ST0, ST1, 2);
    check("post_clear_cnt", int'(contention_cnt), 1);
    $display("clear coincident: cnt=%0d", contention_cnt);

    cyc(ST1, STZ, 3);
    decay_seen = 0;
    cyc(STZ, STZ, HOLDC);
    cyc(ST0, STZ, 2);
    check("expiry_redrive_net", int'(net), int'(ST0));
    check("expiry_redrive_decay", decay_seen, 0);
    $display("expiry re-drive: net=%0d decay pulses=%0d", net, decay_seen);

    cyc(ST0, ST1, 3);
    cyc(ST1, STZ, 3);
    cyc(STZ, STZ, 4);
    decay_seen = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset_net", int'(net), int'(STZ));
    check("midreset_cnt", int'(contention_cnt), 0);
    check("midreset_pulses", int'(contention) + int'(decay), 0);
    cyc(STZ, STZ, 12);
    check("midreset_no_decay", decay_seen, 0);
    $display("reset in hold: net=%0d cnt=%0d", net, contention_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mos_net_resolver.md
# mos_net_resolver

Sequential net-resolution stage placed directly downstream of the NMOS/PMOS pass-gate strength model. It takes the two pass-gate outputs (each ST0/ST1/STZ/STX), resolves them into one wired-net value, filters glitches, and models a bus keeper that retains the last driven level for a bounded time before the net decays to STZ. It also flags and counts drive contention so downstream checkers can catch short circuits.

## Interface
- FILTER_DEPTH, 2: consecutive identical resolved samples required before a new value is accepted; legal range 1..15.
- HOLD_CYCLES, 8: keeper retention time in cycles after both drivers release; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- drv_n  input  2  NMOS pass-gate output, mos_pkg::t_strength.
- drv_p  input  2  PMOS pass-gate output, mos_pkg::t_strength.
- cnt_clr  input  1  synchronous clear of contention_cnt.
- net  output  2  resolved, filtered net value, t_strength.
- contention  output  1  one-cycle pulse when the net enters the contention state.
- decay  output  1  one-cycle pulse when keeper retention expires.
- contention_cnt  output  8  saturating count of contention entries.

## Operation
- Combinational resolve r: both STZ -> STZ; exactly one STZ -> the other input; equal values -> that value; ST0 vs ST1 -> STX; any STX -> STX.
- Filter: r is registered every edge. stab_cnt increments while r equals the previous sample and resets to 0 on a mismatch. The value is accepted (a) on the edge where the run length reaches FILTER_DEPTH. A run shorter than FILTER_DEPTH is discarded, and net is unchanged.
- FSM on accepted values:
  - FLOAT (net=STZ): a=ST0/ST1 -> DRIVEN; a=STX -> CONTEND.
  - DRIVEN (net=a): a=ST0/ST1 updates net. a=STX -> CONTEND. a=STZ -> HOLD (keeper build) and loads hold_cnt=HOLD_CYCLES; otherwise -> FLOAT.
  - HOLD (net=last driven value): hold_cnt decrements each cycle. At 0 -> FLOAT with decay=1 for one cycle. a=ST0/ST1 -> DRIVEN; a=STX -> CONTEND.
  - CONTEND (net=STX): a=ST0/ST1 -> DRIVEN; a=STZ -> FLOAT. The keeper never retains STX.
- Contention: contention pulses on every entry into CONTEND. contention_cnt then increments, saturating at 255.
- Counter clear: cnt_clr sets contention_cnt to 0. If cnt_clr coincides with an increment, the clear wins and the result is 0.
- Widths: stab_cnt is 4 bits. hold_cnt is 8 bits, unsigned, with no wrap below 0.

## Timing
- Reset values: net=STZ, contention=0, decay=0, contention_cnt=0. State is FLOAT, and stab_cnt, hold_cnt and the sample register are cleared.
- Step latency: after a clean input step at edge t, net shows the new value after edge t+FILTER_DEPTH-1. With FILTER_DEPTH=1 the latency is one register stage.
- Keeper timing: HOLD is entered at edge e. net keeps the driven value through edge e+HOLD_CYCLES-1, becomes STZ after edge e+HOLD_CYCLES, and decay is high in that same cycle.
- Simultaneous expiry and drive: if a drive value is accepted on the edge where hold_cnt reaches 0, the drive wins. The FSM goes to DRIVEN and no decay pulse is issued.
- Reset mid-operation: rst_n low at any edge returns every register to its reset value on that edge. This discards a partial filter run and any pending hold.
- Pulses are registered outputs; nothing combinational reaches an output.

## Configuration
- MOS_NET_KEEPER_EN defined: the HOLD state, hold_cnt and the decay pulse exist as described above.
- MOS_NET_KEEPER_EN undefined: accepting STZ from DRIVEN goes straight to FLOAT, net=STZ on the next edge. decay is tied to 0, HOLD_CYCLES is ignored, and no hold_cnt flops are generated.

## Structure
- mos_pkg holds:
  - typedef enum logic [1:0] t_strength {ST0, ST1, STZ, STX}. The pass-gate stage migrates to this shared type; the per-device enums with duplicate literals are retired.
  - the resolve function mos_resolve(t_strength, t_strength).
  - the FSM state enum t_net_state {FLOAT, DRIVEN, HOLD, CONTEND}.
- One sub-module, mos_glitch_filter, containing the sample register and stab_cnt. It outputs the accepted value plus an accept strobe. The FSM, keeper and counters stay in the top module.

## Test plan
- Clean drive, defaults: drv_n=ST0, drv_p=STZ held from reset release -> net=ST0 after 2 edges; contention stays 0.
- Glitch rejection: 1-cycle drv_n=ST1 pulse inside a steady ST0 -> net never leaves ST0.
- Keeper decay, keeper enabled, HOLD_CYCLES=8: drive ST1, then both inputs STZ -> net=ST1 for 8 cycles, then STZ with decay high for exactly 1 cycle. Keeper disabled: net=STZ immediately after filter latency.
- Contention: drv_n=ST0, drv_p=ST1 -> net=STX, one contention pulse, contention_cnt=1. Repeat 300 times -> count saturates at 255. cnt_clr coincident with an entry -> count 0.
- Boundary: re-drive ST0 accepted on the exact expiry edge -> net=ST0, no decay pulse. rst_n low during HOLD -> net=STZ and all counters 0 on the next cycle.
